// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_arbiter_pkg
// Brief   : Shared types, default widths and index helper for the regfile
//           write-port arbiter and its round-robin picker.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_LOCK = 8;

    // ARB: free round-robin arbitration; LOCKED: one owner holds the port
    typedef enum logic [0:0] {
        ARB_ST_ARB    = 1'b0,
        ARB_ST_LOCKED = 1'b1
    } arb_state_t;

    // Requester index reached by stepping 'offset' places past 'base', wrapping at n
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_priority_picker
// Brief   : Combinational round-robin picker. Searches ptr+1, ptr+2, ...
//           (wrapping) for the first set request bit and returns it one-hot,
//           as an index, and as an any-grant flag.
// Revision: 1.0 - initial release
// ============================================================================
module rr_priority_picker
    import regfile_write_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    // First requester after ptr wins; ptr itself is checked last
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any_grant && req[rr_index(int'(ptr), k, NUM_REQ)]) begin
                grant[rr_index(int'(ptr), k, NUM_REQ)] = 1'b1;
                grant_idx = IDX_W'(rr_index(int'(ptr), k, NUM_REQ));
                any_grant = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_arbiter
// Brief   : Shares the regfile write port among NUM_REQ requesters using
//           round-robin arbitration with an optional burst lock. The winning
//           write is registered and presented to the regfile one cycle later.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter  int NUM_REQ  = DEF_NUM_REQ,
    parameter  int ADDR_W   = DEF_ADDR_W,
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int MAX_LOCK = DEF_MAX_LOCK,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      write_enable,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic [IDX_W-1:0]          write_id,
    output logic                      busy
);

    // lock_cnt counts transfers already made in the burst (1..MAX_LOCK-1)
    localparam int               CNT_W    = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_lock_cnt;
    logic               r_write_enable;
    logic [ADDR_W-1:0]  r_write_addr;
    logic [DATA_W-1:0]  r_write_data;
    logic [IDX_W-1:0]   r_write_id;

    logic [NUM_REQ-1:0] w_owner_mask;
    logic               w_owner_hold;
    logic [NUM_REQ-1:0] w_req_mask;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_xfer;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_sel_lock;

    // While the owner keeps requesting, everyone else is masked; once it drops
    // valid the lock is void and plain arbitration runs in that same cycle.
    // ptr equals the owner in LOCKED, so the owner then has lowest priority.
    assign w_owner_mask = NUM_REQ'(1) << r_owner;
    assign w_owner_hold = (r_state == ARB_ST_LOCKED) && req_valid[r_owner];
    assign w_req_mask   = rst          ? '0 :
                          w_owner_hold ? (req_valid & w_owner_mask) : req_valid;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req       (w_req_mask),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_grant (w_xfer)
    );

    assign req_ready  = w_grant;
    assign w_sel_addr = req_addr[w_grant_idx*ADDR_W +: ADDR_W];
    assign w_sel_data = req_data[w_grant_idx*DATA_W +: DATA_W];
    assign w_sel_lock = req_lock[w_grant_idx];

    // Arbitration state, lock bookkeeping and the write output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ARB_ST_ARB;
            r_ptr          <= IDX_W'(NUM_REQ - 1);
            r_owner        <= '0;
            r_lock_cnt     <= '0;
            r_write_enable <= 1'b0;
            r_write_addr   <= '0;
            r_write_data   <= '0;
            r_write_id     <= '0;
        end else begin
            r_write_enable <= w_xfer;
            if (w_xfer) begin
                r_write_addr <= w_sel_addr;
                r_write_data <= w_sel_data;
                r_write_id   <= w_grant_idx;
                r_ptr        <= w_grant_idx;
            end

            if (w_xfer && w_owner_hold) begin
                // Burst continues unless the owner ends it or hits the cap
                if (w_sel_lock && (r_lock_cnt != CNT_LAST)) begin
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                end else begin
                    r_state    <= ARB_ST_ARB;
                    r_lock_cnt <= '0;
                end
            end else if (w_xfer && w_sel_lock && (MAX_LOCK > 1)) begin
                r_state    <= ARB_ST_LOCKED;
                r_owner    <= w_grant_idx;
                r_lock_cnt <= CNT_W'(1);
            end else begin
                r_state    <= ARB_ST_ARB;
                r_lock_cnt <= '0;
            end
        end
    end

    assign write_enable = r_write_enable;
    assign write_addr   = r_write_addr;
    assign write_data   = r_write_data;
    assign write_id     = r_write_id;
    assign busy         = (r_state == ARB_ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_write_arbiter
// Brief   : Self-checking bench for regfile_write_arbiter with an attached
//           32-entry regfile model and a scoreboard of expected writes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            write_enable;
    logic [AW-1:0]   write_addr;
    logic [DW-1:0]   write_data;
    logic [1:0]      write_id;
    logic            busy;

    logic [AW-1:0]   a [N];
    logic [DW-1:0]   d [N];

    logic [DW-1:0]   rf [32];
    logic [AW-1:0]   read0_addr;
    logic [AW-1:0]   read1_addr;
    logic [DW-1:0]   read0_data;
    logic [DW-1:0]   read1_data;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    id;
    } wr_t;

    wr_t  exp_q [$];
    wr_t  mon_exp;
    wr_t  mon_got;
    logic mon_en = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NUM_REQ  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_LOCK (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_lock     (req_lock),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_id     (write_id),
        .busy         (busy)
    );

    // Pack per-requester address/data onto the DUT buses
    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_data[i*DW +: DW] = d[i];
        end
    end

    // Regfile model: one write port, two combinational read ports
    always @(posedge clk) begin
        if (write_enable) rf[write_addr] <= write_data;
    end
    assign read0_data = rf[read0_addr];
    assign read1_data = rf[read1_addr];

    // Scoreboard monitor: every committed write must match the next expected one
    always @(negedge clk) begin
        if (mon_en && write_enable) begin
            tests++;
            mon_got = {write_addr, write_data, write_id};
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got addr=%0d data=%0h id=%0d, want no write",
                         write_addr, write_data, write_id);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    fails++;
                    $display("FAIL sb_write: got addr=%0d data=%0h id=%0d, want addr=%0d data=%0h id=%0d",
                             mon_got.addr, mon_got.data, mon_got.id,
                             mon_exp.addr, mon_exp.data, mon_exp.id);
                end
            end
        end
    end

    task automatic push_exp(input int id);
        exp_q.push_back({a[id], d[id], 2'(id)});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b0001;
        req_lock  = 4'b0000;
        read0_addr = '0;
        read1_addr = '0;
        for (int i = 0; i < N; i++) begin
            a[i] = AW'(i + 3);
            d[i] = DW'(9 + i);
        end
        repeat (2) @(negedge clk);
        #2;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        tests++;
        if ({write_enable, write_addr, write_data, write_id, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%0h id=%0d busy=%b want all 0",
                     write_enable, write_addr, write_data, write_id, busy);
        end
        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0010; a[1] = 5'd15; d[1] = 32'd15;
        #2;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL single_ready: got %b want 0010", req_ready);
        end
        push_exp(1);
        @(negedge clk);
        req_valid = '0;
        #2;
        tests++;
        if ({write_enable, write_addr, write_data, write_id} !== {1'b1, 5'd15, 32'd15, 2'd1}) begin
            fails++;
            $display("FAIL single_write: got we=%b addr=%0d data=%0d id=%0d want 1/15/15/1",
                     write_enable, write_addr, write_data, write_id);
        end
        @(negedge clk);
        read0_addr = 5'd15;
        #2;
        tests++;
        if (read0_data !== 32'd15) begin
            fails++;
            $display("FAIL single_readback: got %0d want 15", read0_data);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rdy;
        // Park the pointer on requester 3 so the rotation starts at 0
        @(negedge clk);
        req_valid = 4'b1000; a[3] = 5'd1; d[3] = 32'h300;
        #2;
        tests++;
        if (req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL rr_setup_ready: got %b want 1000", req_ready);
        end
        push_exp(3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            for (int i = 0; i < N; i++) begin
                a[i] = AW'(16 + i);
                d[i] = DW'(1000 + k * 10 + i);
            end
            #2;
            exp_rdy = 4'b0001 << (k % 4);
            tests++;
            if (req_ready !== exp_rdy) begin
                fails++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy);
            end
            tests++;
            if (write_enable !== 1'b1) begin
                fails++;
                $display("FAIL rr_we[%0d]: got %b want 1", k, write_enable);
            end
            push_exp(k % 4);
        end
        @(negedge clk);
        req_valid = '0;
        #2;
    endtask

    task automatic test_lock_burst();
        @(negedge clk);
        req_valid = 4'b0100; req_lock = 4'b0100; a[2] = 5'd8; d[2] = 32'h208;
        #2;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL burst_first_ready: got %b want 0100", req_ready);
        end
        push_exp(2);
        for (int w = 1; w <= 3; w++) begin
            @(negedge clk);
            req_valid = 4'b0101;
            req_lock  = (w < 3) ? 4'b0100 : 4'b0000;
            a[2] = AW'(8 + w); d[2] = DW'(32'h208 + w);
            a[0] = 5'd20;      d[0] = 32'h20;
            #2;
            tests++;
            if (req_ready !== 4'b0100) begin
                fails++;
                $display("FAIL burst_ready[%0d]: got %b want 0100", w, req_ready);
            end
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL burst_busy[%0d]: got %b want 1", w, busy);
            end
            push_exp(2);
        end
        @(negedge clk);
        req_valid = 4'b0001; req_lock = '0;
        #2;
        tests++;
        if ({req_ready, busy} !== {4'b0001, 1'b0}) begin
            fails++;
            $display("FAIL burst_after: got ready=%b busy=%b want 0001/0", req_ready, busy);
        end
        push_exp(0);
        @(negedge clk);
        req_valid = '0;
        #2;
    endtask

    task automatic test_max_lock();
        int w;
        int exp_id;
        logic exp_busy;
        w = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req_valid = (k <= 8) ? 4'b1010 : 4'b0010;
            req_lock  = 4'b0010;
            a[1] = AW'(w); d[1] = DW'(100 + w);
            a[3] = 5'd30;  d[3] = 32'h333;
            #2;
            exp_id   = (k == 8) ? 3 : 1;
            exp_busy = (k >= 1 && k <= 7);
            tests++;
            if (req_ready !== (4'b0001 << exp_id)) begin
                fails++;
                $display("FAIL maxlock_ready[%0d]: got %b want id %0d", k, req_ready, exp_id);
            end
            tests++;
            if (busy !== exp_busy) begin
                fails++;
                $display("FAIL maxlock_busy[%0d]: got %b want %b", k, busy, exp_busy);
            end
            push_exp(exp_id);
            if (exp_id == 1) w++;
        end
        @(negedge clk);
        req_valid = '0; req_lock = '0;
        #2;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL maxlock_relock: got busy=%b want 1", busy);
        end
        @(negedge clk);
        #2;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL maxlock_idle_release: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_lock_drop();
        @(negedge clk);
        req_valid = 4'b0100; req_lock = 4'b0100; a[2] = 5'd4; d[2] = 32'h44;
        #2;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL drop_first_ready: got %b want 0100", req_ready);
        end
        push_exp(2);
        @(negedge clk);
        req_valid = 4'b0101; a[2] = 5'd5; d[2] = 32'h55; a[0] = 5'd6; d[0] = 32'h66;
        #2;
        tests++;
        if ({req_ready, busy} !== {4'b0100, 1'b1}) begin
            fails++;
            $display("FAIL drop_locked: got ready=%b busy=%b want 0100/1", req_ready, busy);
        end
        push_exp(2);
        @(negedge clk);
        req_valid = 4'b0001; req_lock = '0;
        #2;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL drop_same_cycle: got %b want 0001", req_ready);
        end
        push_exp(0);
        @(negedge clk);
        req_valid = '0;
        #2;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL drop_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_transfer();
        @(negedge clk);
        req_valid = 4'b0001; req_lock = '0; a[0] = 5'd0; d[0] = 32'd77;
        #2;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL rstx_pre_ready: got %b want 0001", req_ready);
        end
        push_exp(0);
        @(negedge clk);
        req_valid = '0;
        #2;
        @(negedge clk);
        req_valid = 4'b0001; d[0] = 32'd123; rst = 1'b1;
        #2;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL rstx_ready: got %b want 0000", req_ready);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = '0; read1_addr = 5'd0;
        #2;
        tests++;
        if ({write_enable, busy} !== 2'b00) begin
            fails++;
            $display("FAIL rstx_we: got we=%b busy=%b want 0/0", write_enable, busy);
        end
        tests++;
        if (read1_data !== 32'd77) begin
            fails++;
            $display("FAIL rstx_unchanged: got %0d want 77", read1_data);
        end
        @(negedge clk);
        req_valid = 4'b0001;
        #2;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL rstx_retry_ready: got %b want 0001", req_ready);
        end
        push_exp(0);
        @(negedge clk);
        req_valid = '0;
        #2;
        @(negedge clk);
        #2;
        tests++;
        if (read1_data !== 32'd123) begin
            fails++;
            $display("FAIL rstx_readback: got %0d want 123", read1_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock_burst();
        test_max_lock();
        test_lock_drop();
        test_reset_mid_transfer();
        @(negedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d writes outstanding want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
